// File: rtl/exec_if.sv
// exec_if: issue handshake and register-file write port of the execute stage.
interface exec_if #(
    parameter int count = 3,
    parameter int DW = 8
);
    logic start, ready_o, busy, wb_en, cout_we;
    logic [2:0] op;
    logic [count-2:0] rs_idx, wb_rs;
    logic [DW-1:0] rs_val, rt_val, wb_data, cout_data;
    modport master (
        output start, op, rs_idx, rs_val, rt_val,
        input ready_o, busy, wb_en, wb_rs, wb_data, cout_we, cout_data
    );
    modport slave (
        input start, op, rs_idx, rs_val, rt_val,
        output ready_o, busy, wb_en, wb_rs, wb_data, cout_we, cout_data
    );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle ALU ops, iterative shifts and a shift-add multiply,
// writing the result to the register file and the carry/high half to COUT.
module exec_unit #(
    parameter int count = 3,
    parameter int DW = 8
) (
    input logic clk,
    input logic rst_n,
    exec_if.slave bus
);
    localparam int CW = $clog2(DW) + 1;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
                           OP_SLL = 3'd4, OP_SRL = 3'd5, OP_MUL = 3'd6, OP_MOV = 3'd7;
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, WB} state_t;
    state_t state, state_n;
    logic [2:0] op_q, op_n;
    logic [count-2:0] rs_q, rs_n, wb_rs_q;
    logic [DW-1:0] hi, lo, hi_n, lo_n, mplier, mplier_n, res, cres, alu, wb_data_q, cout_q;
    logic [2*DW-1:0] mcand, mcand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW:0] sum, dif;
    logic alu_c;
    assign sum = {1'b0, bus.rs_val} + {1'b0, bus.rt_val};
    assign dif = {1'b0, bus.rs_val} - {1'b0, bus.rt_val};
    assign alu = bus.op == OP_ADD ? sum[DW-1:0] :
                 bus.op == OP_SUB ? dif[DW-1:0] :
                 bus.op == OP_AND ? bus.rs_val & bus.rt_val :
                 bus.op == OP_XOR ? bus.rs_val ^ bus.rt_val : bus.rt_val;
    assign alu_c = (bus.op == OP_ADD && sum[DW]) || (bus.op == OP_SUB && dif[DW]);
    always_comb begin
        state_n = state;
        op_n = op_q;
        rs_n = rs_q;
        hi_n = hi;
        lo_n = lo;
        mcand_n = mcand;
        mplier_n = mplier;
        cnt_n = cnt;
        res = '0;
        cres = '0;
        case (state)
            IDLE: if (bus.start) begin
                op_n = bus.op;
                rs_n = bus.rs_idx;
                if (bus.op == OP_SLL || bus.op == OP_SRL) begin
                    hi_n = '0;
                    lo_n = bus.rs_val;
                    cnt_n = CW'(bus.rt_val[2:0]);
                    state_n = bus.rt_val[2:0] == 3'd0 ? WB : SHIFT;
                    res = bus.rs_val;
                end else if (bus.op == OP_MUL) begin
                    hi_n = '0;
                    lo_n = '0;
                    mcand_n = {{DW{1'b0}}, bus.rs_val};
                    mplier_n = bus.rt_val;
                    cnt_n = CW'(DW);
                    state_n = MUL;
                end else begin
                    res = alu;
                    cres = {{(DW-1){1'b0}}, alu_c};
                    state_n = WB;
                end
            end
            SHIFT: begin
                if (op_q == OP_SLL) {hi_n, lo_n} = {hi, lo} << 1;
                else {lo_n, hi_n} = {lo, hi} >> 1;
                cnt_n = cnt - 1'b1;
                res = lo_n;
                cres = hi_n;
                state_n = cnt == CW'(1) ? WB : SHIFT;
            end
            MUL: begin
                {hi_n, lo_n} = {hi, lo} + (mplier[0] ? mcand : '0);
                mcand_n = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n = cnt - 1'b1;
                res = lo_n;
                cres = hi_n;
                state_n = cnt == CW'(1) ? WB : MUL;
            end
            default: state_n = IDLE;
        endcase
    end
    // Write-port registers load only on entry to WB so they hold until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q <= '0;
            rs_q <= '0;
            hi <= '0;
            lo <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            wb_rs_q <= '0;
            wb_data_q <= '0;
            cout_q <= '0;
        end else begin
            state <= state_n;
            op_q <= op_n;
            rs_q <= rs_n;
            hi <= hi_n;
            lo <= lo_n;
            mcand <= mcand_n;
            mplier <= mplier_n;
            cnt <= cnt_n;
            if (state_n == WB) begin
                wb_rs_q <= rs_n;
                wb_data_q <= res;
                cout_q <= cres;
            end
        end
    end
    assign bus.ready_o = state == IDLE;
    assign bus.busy = state != IDLE;
    assign bus.wb_en = state == WB;
    assign bus.cout_we = state == WB && op_q != OP_MOV;
    assign bus.wb_rs = wb_rs_q;
    assign bus.wb_data = wb_data_q;
    assign bus.cout_data = cout_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit; an independent arithmetic model predicts each
// write-back, and the monitor compares every wb_en pulse against the oldest prediction.
module tb_exec_unit;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, XOR_ = 3'd3,
                           SLL = 3'd4, SRL = 3'd5, MUL = 3'd6, MOV = 3'd7;
    typedef struct packed {
        logic [1:0] rs;
        logic [7:0] d;
        logic [7:0] c;
        logic cwe;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];
    exp_t m;
    exec_if #(.count(3), .DW(8)) bus();
    exec_unit #(.count(3), .DW(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t model(input logic [2:0] o, input logic [1:0] r, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] w;
        exp_t e;
        e.rs = r;
        e.cwe = o != MOV;
        w = 16'h0000;
        case (o)
            ADD: w = {8'h00, a} + {8'h00, b};
            SUB: w = {7'h00, a < b, a - b};
            AND_: w = {8'h00, a & b};
            XOR_: w = {8'h00, a ^ b};
            SLL: w = {8'h00, a} << b[2:0];
            SRL: w = {a, 8'h00} >> b[2:0];
            MUL: w = 16'(a) * 16'(b);
            default: w = {8'h00, b};
        endcase
        e.d = o == SRL ? w[15:8] : w[7:0];
        e.c = o == SRL ? w[7:0] : w[15:8];
        return e;
    endfunction
    function automatic int exp_lat(input logic [2:0] o, input logic [7:0] b);
        return o == MUL ? 9 : (o == SLL || o == SRL) ? int'(b[2:0]) + 1 : 1;
    endfunction
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_en) begin
                chk("wb_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m = sb.pop_front();
                    chk("wb_rs", int'(bus.wb_rs), int'(m.rs));
                    chk("wb_data", int'(bus.wb_data), int'(m.d));
                    chk("cout_we", int'(bus.cout_we), int'(m.cwe));
                    if (m.cwe) chk("cout_data", int'(bus.cout_data), int'(m.c));
                end
            end else begin
                chk("cout_we_idle", int'(bus.cout_we), 0);
            end
        end
    end
    // Called at a negedge; returns at the negedge after ready_o comes back.
    task automatic issue(input logic [2:0] o, input logic [1:0] r, input logic [7:0] a, input logic [7:0] b);
        int n, lat;
        n = 0;
        while (!bus.ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(bus.ready_o), 1);
        bus.start = 1'b1;
        bus.op = o;
        bus.rs_idx = r;
        bus.rs_val = a;
        bus.rt_val = b;
        sb.push_back(model(o, r, a, b));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.wb_en && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat(o, b));
        @(negedge clk);
        chk("ready_after_wb", int'(bus.ready_o), 1);
    endtask
    initial begin
        int na;
        bus.start = 1'b0;
        bus.op = '0;
        bus.rs_idx = '0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(bus.ready_o), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wb_en", int'(bus.wb_en), 0);
        chk("rst_cout_we", int'(bus.cout_we), 0);
        chk("rst_wb_data", int'(bus.wb_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(ADD, 2'd2, 8'hF0, 8'h20);
        issue(SUB, 2'd1, 8'h05, 8'h07);
        issue(MOV, 2'd3, 8'h00, 8'h5A);
        issue(AND_, 2'd0, 8'hCC, 8'hAA);
        issue(XOR_, 2'd1, 8'hCC, 8'hAA);
        issue(SLL, 2'd2, 8'hB3, 8'h03);
        issue(SRL, 2'd3, 8'hB3, 8'h03);
        issue(SLL, 2'd0, 8'hB3, 8'h00);
        issue(SRL, 2'd1, 8'hB3, 8'hF8);
        issue(MUL, 2'd2, 8'hFF, 8'hFF);
        issue(MUL, 2'd3, 8'h0F, 8'h11);
        // Reset mid-multiply: no write may escape and all outputs clear at once.
        bus.start = 1'b1;
        bus.op = MUL;
        bus.rs_idx = 2'd1;
        bus.rs_val = 8'h0F;
        bus.rt_val = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(bus.ready_o), 1);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_wb_en", int'(bus.wb_en), 0);
        chk("mid_rst_cout_we", int'(bus.cout_we), 0);
        chk("mid_rst_wb_rs", int'(bus.wb_rs), 0);
        chk("mid_rst_wb_data", int'(bus.wb_data), 0);
        chk("mid_rst_cout_data", int'(bus.cout_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_ready", int'(bus.ready_o), 1);
        // Start held high with changing operands through a shift: single accept only.
        bus.start = 1'b1;
        bus.op = SRL;
        bus.rs_idx = 2'd3;
        bus.rs_val = 8'hB3;
        bus.rt_val = 8'h03;
        sb.push_back(model(SRL, 2'd3, 8'hB3, 8'h03));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_busy", int'(bus.ready_o), 0);
            bus.op = ADD;
            bus.rs_idx = 2'($urandom);
            bus.rs_val = 8'($urandom);
            bus.rt_val = 8'($urandom);
        end
        @(negedge clk);
        chk("hold_wb", int'(bus.wb_en), 1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_ready", int'(bus.ready_o), 1);
        // Back-to-back ADDs with start held: one accept every two cycles.
        na = 0;
        bus.start = 1'b1;
        bus.op = ADD;
        for (int i = 0; i < 8; i++) begin
            if (bus.ready_o) begin
                bus.rs_idx = 2'($urandom);
                bus.rs_val = 8'($urandom);
                bus.rt_val = 8'($urandom);
                sb.push_back(model(ADD, bus.rs_idx, bus.rs_val, bus.rt_val));
                na++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_accepts", na, 4);
        @(negedge clk);
        for (int i = 0; i < 24; i++)
            issue(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end
endmodule
